// File: rtl/instr_align_buffer.sv
// Realigns word-aligned fetch data into a halfword stream and presents one instruction per handshake.
// Define IBUF_COMPRESS_EN to enable 16-bit (RVC) instruction support; without it every head is 32-bit.
module instr_align_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_word,
    input  logic                      in_error,
    input  logic                      flush,
    input  logic [31:0]               flush_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [31:0]               out_pc,
    output logic                      out_compressed,
    output logic                      out_error,
    output logic [$clog2(2*DEPTH):0]  count
);

    localparam int ENTRIES = 2 * DEPTH;
    localparam int PW      = $clog2(ENTRIES);
    localparam int CW      = PW + 1;

    logic [15:0]   hw_q  [ENTRIES];
    logic          err_q [ENTRIES];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_p1, wr_ptr_p1, wr_hi_idx;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic          skip_q, skip_d;

    logic [15:0]   h0, h1;
    logic          e0, e1;
    logic          head_is32;
    logic          flush_skip;
    logic          push, pop, pop_two;
    logic [1:0]    push_cnt, pop_cnt;
    logic [31:0]   pc_inc;
    logic          wr_lo_en, wr_hi_en;
    logic          unused_flush_pc0;

    assign unused_flush_pc0 = flush_pc[0];

    assign rd_ptr_p1 = rd_ptr_q + PW'(1);
    assign wr_ptr_p1 = wr_ptr_q + PW'(1);

    assign h0 = hw_q[rd_ptr_q];
    assign h1 = hw_q[rd_ptr_p1];
    assign e0 = err_q[rd_ptr_q];
    assign e1 = err_q[rd_ptr_p1];

`ifdef IBUF_COMPRESS_EN
    assign head_is32  = (h0[1:0] == 2'b11);
    assign flush_skip = flush_pc[1];
    assign pc_inc     = pop_two ? 32'd4 : 32'd2;
`else
    assign head_is32  = 1'b1;
    assign flush_skip = 1'b0;
    assign pc_inc     = 32'd4;
`endif

    // Only registered state feeds the handshakes, so nothing here loops back through decode.
    assign in_ready  = (count_q <= CW'(ENTRIES - 2));
    assign out_valid = (count_q != '0) && (!head_is32 || e0 || (count_q >= CW'(2)));
    assign out_pc    = head_pc_q;
    assign count     = count_q;

    always_comb begin
        out_instr      = 32'h0;
        out_compressed = 1'b0;
        out_error      = 1'b0;
        if (out_valid) begin
            if (e0) begin
                out_error = 1'b1;
            end else if (head_is32) begin
                out_instr = {h1, h0};
                out_error = e1;
            end else begin
                out_instr      = {16'h0, h0};
                out_compressed = 1'b1;
            end
        end
    end

    always_comb begin
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
        pop_two   = head_is32 && !e0;
        pop_cnt   = !pop ? 2'd0 : (pop_two ? 2'd2 : 2'd1);
        push_cnt  = !push ? 2'd0 : (skip_q ? 2'd1 : 2'd2);
        // With skip set the lower halfword precedes the restart PC and is dropped.
        wr_lo_en  = push && !skip_q;
        wr_hi_en  = push;
        wr_hi_idx = skip_q ? wr_ptr_q : wr_ptr_p1;
        rd_ptr_d  = rd_ptr_q + PW'(pop_cnt);
        wr_ptr_d  = wr_ptr_q + PW'(push_cnt);
        count_d   = count_q + CW'(push_cnt) - CW'(pop_cnt);
        head_pc_d = pop ? head_pc_q + pc_inc : head_pc_q;
        skip_d    = skip_q && !push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (wr_lo_en) begin
                hw_q[wr_ptr_q]  <= in_word[15:0];
                err_q[wr_ptr_q] <= in_error;
            end
            if (wr_hi_en) begin
                hw_q[wr_hi_idx]  <= in_word[31:16];
                err_q[wr_hi_idx] <= in_error;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= RESET_PC;
            skip_q    <= 1'b0;
        end else if (flush) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= {flush_pc[31:1], 1'b0};
            skip_q    <= flush_skip;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            head_pc_q <= head_pc_d;
            skip_q    <= skip_d;
        end
    end

endmodule

// File: tb/tb_instr_align_buffer.sv
// Directed self-checking bench for instr_align_buffer (DEPTH=4); expectations follow IBUF_COMPRESS_EN.
module tb_instr_align_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_error;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_compressed;
    logic        out_error;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    instr_align_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_error(in_error),
        .flush(flush), .flush_pc(flush_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_compressed(out_compressed), .out_error(out_error), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; in_word = 32'h0; in_error = 1'b0;
        flush = 1'b0; flush_pc = 32'h0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        step();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=00000000", out_pc); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=00000000", out_instr); end
        checks++; if (out_error !== 1'b0 || out_compressed !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", out_error, out_compressed); end
        rst = 1'b1;
        $display("reset: count=%0d out_valid=%b in_ready=%b", count, out_valid, in_ready);
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1'b1; in_word = 32'h0013_0093;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_instr !== 32'h0013_0093) begin failures++; $display("FAIL basic_instr got=%h exp=00130093", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL basic_pc got=%h exp=00000000", out_pc); end
        checks++; if (out_compressed !== 1'b0) begin failures++; $display("FAIL basic_compressed got=%b exp=0", out_compressed); end
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0013_0093) begin failures++; $display("FAIL basic_hold got=%b/%h exp=1/00130093", out_valid, out_instr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL basic_pop got=%b/%0d exp=0/0", out_valid, count); end
        checks++; if (out_pc !== 32'h4) begin failures++; $display("FAIL basic_next_pc got=%h exp=00000004", out_pc); end
        $display("basic: instr=%h pc=%h", 32'h0013_0093, out_pc);
    endtask

    task automatic test_compressed();
        logic [31:0] e_i0, e_i1, e_pc_end;
        logic        e_c;
`ifdef IBUF_COMPRESS_EN
        e_i0 = 32'h0000_4501; e_i1 = 32'h0000_0001; e_c = 1'b1; e_pc_end = 32'h4;
`else
        e_i0 = 32'h0001_4501; e_i1 = 32'h0; e_c = 1'b0; e_pc_end = 32'h4;
`endif
        do_reset();
        in_valid = 1'b1; in_word = 32'h0001_4501;
        step();
        in_valid = 1'b0;
        checks++; if (out_instr !== e_i0 || out_pc !== 32'h0) begin failures++; $display("FAIL comp_first got=%h@%h exp=%h@00000000", out_instr, out_pc, e_i0); end
        checks++; if (out_compressed !== e_c) begin failures++; $display("FAIL comp_first_flag got=%b exp=%b", out_compressed, e_c); end
        out_ready = 1'b1;
        step();
`ifdef IBUF_COMPRESS_EN
        checks++; if (out_valid !== 1'b1 || out_instr !== e_i1 || out_pc !== 32'h2) begin failures++; $display("FAIL comp_second got=%b/%h@%h exp=1/%h@00000002", out_valid, out_instr, out_pc, e_i1); end
        checks++; if (out_compressed !== 1'b1) begin failures++; $display("FAIL comp_second_flag got=%b exp=1", out_compressed); end
        step();
`endif
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_pc !== e_pc_end) begin failures++; $display("FAIL comp_end got=%b@%h exp=0@%h", out_valid, out_pc, e_pc_end); end
        $display("compressed: first=%h last_pc=%h", e_i0, out_pc);
    endtask

    task automatic test_straddle();
        logic [31:0] e_i0, e_i1, e_pc1;
`ifdef IBUF_COMPRESS_EN
        e_i0 = 32'h0000_4501; e_i1 = 32'h0013_0093; e_pc1 = 32'h2;
`else
        e_i0 = 32'h0093_4501; e_i1 = 32'h4505_0013; e_pc1 = 32'h4;
`endif
        do_reset();
        in_valid = 1'b1; in_word = 32'h0093_4501;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_instr !== e_i0 || out_pc !== 32'h0) begin failures++; $display("FAIL straddle_first got=%b/%h@%h exp=1/%h@00000000", out_valid, out_instr, out_pc, e_i0); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL straddle_wait got=%b exp=0", out_valid); end
        in_valid = 1'b1; in_word = 32'h4505_0013;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_instr !== e_i1 || out_pc !== e_pc1) begin failures++; $display("FAIL straddle_second got=%b/%h@%h exp=1/%h@%h", out_valid, out_instr, out_pc, e_i1, e_pc1); end
`ifdef IBUF_COMPRESS_EN
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0000_4505 || out_pc !== 32'h6 || out_compressed !== 1'b1) begin failures++; $display("FAIL straddle_third got=%b/%h@%h c=%b exp=1/00004505@00000006 c=1", out_valid, out_instr, out_pc, out_compressed); end
`endif
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h8) begin failures++; $display("FAIL straddle_end got=%b@%h exp=0@00000008", out_valid, out_pc); end
        $display("straddle: second=%h@%h", e_i1, e_pc1);
    endtask

    task automatic test_full();
        do_reset();
        in_valid = 1'b1; in_word = 32'h0013_0093;
        for (int i = 0; i < 4; i++) step();
        checks++; if (count !== 4'd8 || in_ready !== 1'b0) begin failures++; $display("FAIL full_count got=%0d/%b exp=8/0", count, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_overflow got=%0d exp=8", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 4'd6 || in_ready !== 1'b1 || out_pc !== 32'h4) begin failures++; $display("FAIL full_pop got=%0d/%b@%h exp=6/1@00000004", count, in_ready, out_pc); end
        $display("full: count=%0d in_ready=%b", count, in_ready);
    endtask

    task automatic test_flush();
        logic [31:0] e_i;
        logic [3:0]  e_cnt;
        logic        e_c;
`ifdef IBUF_COMPRESS_EN
        e_i = 32'h0000_4505; e_cnt = 4'd1; e_c = 1'b1;
`else
        e_i = 32'h4505_0000; e_cnt = 4'd2; e_c = 1'b0;
`endif
        do_reset();
        in_valid = 1'b1; in_word = 32'h0013_0093;
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1; flush_pc = 32'h0000_0102; out_ready = 1'b1; in_word = 32'h1111_1113;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (count !== 4'd0 || out_valid !== 1'b0 || out_pc !== 32'h102) begin failures++; $display("FAIL flush_empty got=%0d/%b@%h exp=0/0@00000102", count, out_valid, out_pc); end
        in_valid = 1'b1; in_word = 32'h4505_0000;
        step();
        in_valid = 1'b0;
        checks++; if (count !== e_cnt) begin failures++; $display("FAIL flush_refill_count got=%0d exp=%0d", count, e_cnt); end
        checks++; if (out_valid !== 1'b1 || out_instr !== e_i || out_pc !== 32'h102 || out_compressed !== e_c) begin failures++; $display("FAIL flush_refill got=%b/%h@%h c=%b exp=1/%h@00000102 c=%b", out_valid, out_instr, out_pc, out_compressed, e_i, e_c); end
        $display("flush: instr=%h pc=%h", out_instr, out_pc);
    endtask

    task automatic test_error();
        logic [31:0] e_i0, e_i1, e_pc1, e_pc2;
        logic        e_err0, e_err1;
`ifdef IBUF_COMPRESS_EN
        e_i0 = 32'h0000_4501; e_err0 = 1'b0;
        e_i1 = 32'h0013_0093; e_err1 = 1'b1; e_pc1 = 32'h2; e_pc2 = 32'h6;
`else
        e_i0 = 32'h0093_4501; e_err0 = 1'b0;
        e_i1 = 32'h0;         e_err1 = 1'b1; e_pc1 = 32'h4; e_pc2 = 32'h8;
`endif
        do_reset();
        in_valid = 1'b1; in_word = 32'h0093_4501; in_error = 1'b0;
        step();
        in_word = 32'h0000_0013; in_error = 1'b1;
        step();
        in_valid = 1'b0; in_error = 1'b0;
        checks++; if (out_instr !== e_i0 || out_error !== e_err0 || out_pc !== 32'h0) begin failures++; $display("FAIL err_first got=%h e=%b@%h exp=%h e=%b@00000000", out_instr, out_error, out_pc, e_i0, e_err0); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_instr !== e_i1 || out_error !== e_err1 || out_pc !== e_pc1) begin failures++; $display("FAIL err_second got=%b/%h e=%b@%h exp=1/%h e=%b@%h", out_valid, out_instr, out_error, out_pc, e_i1, e_err1, e_pc1); end
        step();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0 || out_error !== 1'b1 || out_pc !== e_pc2 || out_compressed !== 1'b0) begin failures++; $display("FAIL err_third got=%b/%h e=%b c=%b@%h exp=1/00000000 e=1 c=0@%h", out_valid, out_instr, out_error, out_compressed, out_pc, e_pc2); end
        $display("error: second=%h pc=%h third_pc=%h", e_i1, e_pc1, out_pc);
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0030_0193;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_word = words[i];
            step();
            checks++; if (count !== 4'd2 || out_instr !== words[i] || out_pc !== 32'(4 * i)) begin failures++; $display("FAIL b2b_%0d got=%0d/%h@%h exp=2/%h@%h", i, count, out_instr, out_pc, words[i], 32'(4 * i)); end
            $display("b2b: slot=%0d instr=%h pc=%h", i, out_instr, out_pc);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        checks++; if (count !== 4'd0 || out_pc !== 32'hC) begin failures++; $display("FAIL b2b_drain got=%0d@%h exp=0@0000000c", count, out_pc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_compressed();
        test_straddle();
        test_full();
        test_flush();
        test_error();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
